l3_bus_responder: RTL and testbench

// Responder end of the shared L3 bus: accepts arbiter-granted GETS/GETX/PUTX/INV requests from the per-core L1/L2 controllers,

---
 rtl/coherence_pkg.sv | 36 +++
 rtl/l3_line_store.sv | 62 ++++++
 rtl/l3_bus_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_l3_bus_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_pkg.sv
// Shared types and sizes for the L3 bus responder.
//   bus_cmd_e    : bus request command encoding (GETS/GETX/PUTX/INV)
//   resp_state_e : responder FSM states
//   line_word()  : extract one 32-bit word from a 128-bit line (word0 in bits [31:0])
package coherence_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 4;

  typedef enum logic [1:0] {
    CMD_GETS = 2'd0,
    CMD_GETX = 2'd1,
    CMD_PUTX = 2'd2,
    CMD_INV  = 2'd3
  } bus_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_LOOKUP,
    ST_RECV,
    ST_MEM_WB,
    ST_MEM_FILL,
    ST_RESP_HDR,
    ST_RESP_DATA
  } resp_state_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        sel);
    line_word = line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/l3_line_store.sv
// Direct-mapped L3 line array: tag, valid, dirty and 128-bit data per set.
// One registered read port (results appear the cycle after rd_idx is presented)
// and one write port. Only valid/dirty are cleared by reset; tag/data are plain
// storage qualified by valid.
// Ports:
//   clk, reset              clock, async active-high reset
//   rd_idx                  set index to read
//   rd_valid/dirty/tag/data registered read results
//   wr_en, wr_idx, wr_tag,  write a whole line; the set becomes valid with
//   wr_data, wr_dirty       the given dirty bit
module l3_line_store
  import coherence_pkg::*;
#(
  parameter int  SETS  = 64,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              wr_dirty
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      rd_valid <= 1'b0;
      rd_dirty <= 1'b0;
    end else begin
      rd_valid <= valid_q[rd_idx];
      rd_dirty <= dirty_q[rd_idx];
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        dirty_q[wr_idx] <= wr_dirty;
      end
    end
  end

  always_ff @(posedge clk) begin
    rd_tag  <= tag_mem[rd_idx];
    rd_data <= data_mem[rd_idx];
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/l3_bus_responder.sv
// Responder end of the shared L3 bus. Accepts one granted request at a time,
// collects snoop results, sources the line from a dirty owner, the L3 or main
// memory, and returns a header beat followed by four data beats.
// Ports:
//   clk, reset                      clock, async active-high reset
//   req_valid/cmd/proc/addr/ready   granted request handshake
//   snoop_done/share/dirty          per-core snoop completion and OR'd results
//   bus_wvalid, bus_wdata           data beats from a PUTX writer or dirty owner
//   rsp_valid/is_addr/proc/data/
//   rsp_shared/rsp_last             split-transaction response beats
//   mem_req/we/addr/wdata,
//   mem_rdata, mem_ack              line-granular main-memory port
//
// state     | meaning
// IDLE      | ready for a request
// SNOOP     | waiting for every non-requesting core to report
// LOOKUP    | L3 tag compare on the registered read
// RECV      | collecting four words from the bus (PUTX or dirty owner)
// MEM_WB    | writing the dirty victim back to memory
// MEM_FILL  | reading the requested line from memory
// RESP_HDR  | header beat with the request address
// RESP_DATA | word0..word3
module l3_bus_responder
  import coherence_pkg::*;
#(
  parameter int  NUM_PROC = 4,
  parameter int  L3_SETS  = 64,
  localparam int PROC_W   = $clog2(NUM_PROC),
  localparam int IDX_W    = $clog2(L3_SETS),
  localparam int TAG_W    = ADDR_W - OFFSET_W - IDX_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [1:0]          req_cmd,
  input  logic [PROC_W-1:0]   req_proc,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  input  logic [NUM_PROC-1:0] snoop_done,
  input  logic                snoop_share,
  input  logic                snoop_dirty,
  input  logic                bus_wvalid,
  input  logic [WORD_W-1:0]   bus_wdata,
  output logic                rsp_valid,
  output logic                rsp_is_addr,
  output logic [PROC_W-1:0]   rsp_proc,
  output logic [WORD_W-1:0]   rsp_data,
  output logic                rsp_shared,
  output logic                rsp_last,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [LINE_W-1:0]   mem_wdata,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  resp_state_e         state_q, state_d;
  bus_cmd_e            cmd_q, cmd_d;
  logic [PROC_W-1:0]   proc_q, proc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_PROC-1:0] pend_q, pend_d, req_bit;
  logic                share_q, share_d;
  logic                dirty_q, dirty_d;
  logic                mem_req_q, mem_req_d;
  logic                rdy_q;
  logic [1:0]          beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;

  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_data;
  logic                wr_en, wr_dirty;
  logic [LINE_W-1:0]   wr_data;

  logic [IDX_W-1:0]    idx_q;
  logic [TAG_W-1:0]    tag_q;
  logic                hit;

  assign idx_q = addr_q[IDX_W+OFFSET_W-1:OFFSET_W];
  assign tag_q = addr_q[ADDR_W-1:IDX_W+OFFSET_W];
  assign hit   = rd_valid && (rd_tag == tag_q);

  // The read port always follows the latched address, so the tag/data for the
  // current request are ready by the LOOKUP cycle and stay stable for MEM_WB.
  l3_line_store #(.SETS(L3_SETS)) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx_q),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_tag   (tag_q),
    .wr_data  (wr_data),
    .wr_dirty (wr_dirty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_GETS;
      proc_q    <= '0;
      addr_q    <= '0;
      pend_q    <= '0;
      share_q   <= 1'b0;
      dirty_q   <= 1'b0;
      mem_req_q <= 1'b0;
      rdy_q     <= 1'b0;
      beat_q    <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      proc_q    <= proc_d;
      addr_q    <= addr_d;
      pend_q    <= pend_d;
      share_q   <= share_d;
      dirty_q   <= dirty_d;
      mem_req_q <= mem_req_d;
      rdy_q     <= (state_d == ST_IDLE);
      beat_q    <= beat_d;
      line_q    <= line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    proc_d    = proc_q;
    addr_d    = addr_q;
    pend_d    = pend_q;
    share_d   = share_q;
    dirty_d   = dirty_q;
    mem_req_d = mem_req_q;
    beat_d    = beat_q;
    line_d    = line_q;
    wr_en     = 1'b0;
    wr_dirty  = 1'b0;
    wr_data   = line_q;
    req_bit   = '0;
    req_bit[req_proc] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && rdy_q) begin
          cmd_d   = bus_cmd_e'(req_cmd);
          proc_d  = req_proc;
          addr_d  = req_addr;
          pend_d  = ~req_bit;
          share_d = 1'b0;
          dirty_d = 1'b0;
          beat_d  = '0;
          state_d = (bus_cmd_e'(req_cmd) == CMD_PUTX) ? ST_RECV : ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        pend_d  = pend_q & ~snoop_done;
        share_d = share_q | snoop_share;
        dirty_d = dirty_q | snoop_dirty;
        if (pend_d == '0) begin
          if (cmd_q == CMD_INV) state_d = ST_RESP_HDR;
          else if (dirty_d)     state_d = ST_RECV;
          else                  state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          line_d  = rd_data;
          state_d = ST_RESP_HDR;
        end else begin
          mem_req_d = 1'b1;
          state_d   = (rd_valid && rd_dirty) ? ST_MEM_WB : ST_MEM_FILL;
        end
      end
      ST_RECV: begin
        if (bus_wvalid) begin
          line_d[beat_q*WORD_W +: WORD_W] = bus_wdata;
          beat_d = beat_q + 2'd1;
          // Whole line goes into the L3 in one write on the final beat.
          if (beat_q == 2'd3) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = line_d;
            beat_d   = '0;
            state_d  = ST_RESP_HDR;
          end
        end
      end
      ST_MEM_WB: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_MEM_FILL;
        end
      end
      ST_MEM_FILL: begin
        // Arriving from MEM_WB, mem_req is low for one cycle before the read.
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          wr_en     = 1'b1;
          wr_dirty  = 1'b0;
          wr_data   = mem_rdata;
          line_d    = mem_rdata;
          state_d   = ST_RESP_HDR;
        end
      end
      ST_RESP_HDR: begin
        beat_d  = '0;
        state_d = (cmd_q == CMD_INV || cmd_q == CMD_PUTX) ? ST_IDLE : ST_RESP_DATA;
      end
      ST_RESP_DATA: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = rdy_q;
    rsp_valid   = (state_q == ST_RESP_HDR) || (state_q == ST_RESP_DATA);
    rsp_is_addr = (state_q == ST_RESP_HDR);
    rsp_proc    = rsp_valid ? proc_q : '0;
    rsp_shared  = rsp_valid && (cmd_q == CMD_GETS) && (share_q || dirty_q);
    rsp_last    = ((state_q == ST_RESP_HDR) && (cmd_q == CMD_INV || cmd_q == CMD_PUTX)) ||
                  ((state_q == ST_RESP_DATA) && (beat_q == 2'd3));
    rsp_data    = '0;
    if (state_q == ST_RESP_HDR)       rsp_data = addr_q;
    else if (state_q == ST_RESP_DATA) rsp_data = line_word(line_q, beat_q);

    mem_req   = mem_req_q;
    mem_we    = mem_req_q && (state_q == ST_MEM_WB);
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_we) begin
      mem_addr  = {rd_tag, idx_q, {OFFSET_W{1'b0}}};
      mem_wdata = rd_data;
    end else if (mem_req_q) begin
      mem_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    end
  end

endmodule

// File: tb/tb_l3_bus_responder.sv
// Self-checking bench for l3_bus_responder: directed scenarios plus a random
// phase, all checked against a line-level model of the L3 and main memory.
module tb_l3_bus_responder;
  import coherence_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [1:0]   req_cmd;
  logic [1:0]   req_proc;
  logic [31:0]  req_addr;
  logic         req_ready;
  logic [3:0]   snoop_done;
  logic         snoop_share;
  logic         snoop_dirty;
  logic         bus_wvalid;
  logic [31:0]  bus_wdata;
  logic         rsp_valid;
  logic         rsp_is_addr;
  logic [1:0]   rsp_proc;
  logic [31:0]  rsp_data;
  logic         rsp_shared;
  logic         rsp_last;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  always #5 clk = ~clk;

  l3_bus_responder #(.NUM_PROC(4), .L3_SETS(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_proc(req_proc), .req_addr(req_addr),
    .req_ready(req_ready),
    .snoop_done(snoop_done), .snoop_share(snoop_share), .snoop_dirty(snoop_dirty),
    .bus_wvalid(bus_wvalid), .bus_wdata(bus_wdata),
    .rsp_valid(rsp_valid), .rsp_is_addr(rsp_is_addr), .rsp_proc(rsp_proc),
    .rsp_data(rsp_data), .rsp_shared(rsp_shared), .rsp_last(rsp_last),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [127:0] data;
  } mem_op_t;

  // Model state: L3 by set index, memory by line address.
  bit           l3_v    [64];
  bit           l3_d    [64];
  logic [21:0]  l3_tag  [64];
  logic [127:0] l3_data [64];
  logic [127:0] mem_m [logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic l3_install(input logic [5:0] idx, input logic [21:0] tg,
                            input logic [127:0] line, input bit dirty);
    l3_v[idx]    = 1'b1;
    l3_d[idx]    = dirty;
    l3_tag[idx]  = tg;
    l3_data[idx] = line;
  endtask

  // mode: 0 random snoop timing, 1 all snoops in first cycle, 2 one core per cycle
  task automatic run_txn(input int cmd, input int proc, input logic [31:0] addr,
                         input bit share, input bit dirty, input int mode);
    logic [31:0]  wd [4];
    logic [127:0] wline, exp_line;
    logic [5:0]   idx;
    logic [21:0]  tg;
    logic [1:0]   p;
    logic [31:0]  la;
    logic [39:0]  obs [$];
    logic [39:0]  eb;
    logic [3:0]   sd;
    mem_op_t      exp_mem [$];
    mem_op_t      op, cur;
    int           pulse_c [4];
    int           nwords, last_snoop, share_c, dirty_c, beat_i, next_beat, recv_start;
    int           hdr_c, last_c, delay, w, s;
    bit           exp_sh, dirty_path, done, ack_now, mem_active, stable_ok, busy_ready;
    string        nm;

    p = proc[1:0];
    idx = addr[9:4];
    tg  = addr[31:10];
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    wline = {wd[3], wd[2], wd[1], wd[0]};
    nwords = 0;
    exp_line = '0;
    dirty_path = (cmd < 2) && dirty;

    if (cmd == 2) begin
      l3_install(idx, tg, wline, 1'b1);
    end else if (cmd < 2) begin
      nwords = 4;
      if (dirty) begin
        exp_line = wline;
        l3_install(idx, tg, wline, 1'b1);
      end else if (l3_v[idx] && l3_tag[idx] == tg) begin
        exp_line = l3_data[idx];
      end else begin
        if (l3_v[idx] && l3_d[idx]) begin
          op.we = 1'b1;
          op.addr = {l3_tag[idx], idx, 4'h0};
          op.data = l3_data[idx];
          exp_mem.push_back(op);
          mem_m[op.addr] = op.data;
        end
        la = {addr[31:4], 4'h0};
        if (!mem_m.exists(la)) mem_m[la] = {$urandom, $urandom, $urandom, $urandom};
        op.we = 1'b0;
        op.addr = la;
        op.data = mem_m[la];
        exp_mem.push_back(op);
        exp_line = mem_m[la];
        l3_install(idx, tg, mem_m[la], 1'b0);
      end
    end
    exp_sh = (cmd == 0) && (share || dirty);

    // Snoop schedule (none for PUTX, which skips snooping).
    last_snoop = 0;
    s = 1;
    for (int k = 0; k < 4; k++) begin
      pulse_c[k] = 0;
      if (cmd != 2) begin
        if (k == proc)      pulse_c[k] = ($urandom_range(0, 1) == 1) ? 1 : 0;
        else if (mode == 1) pulse_c[k] = 1;
        else if (mode == 2) pulse_c[k] = s++;
        else                pulse_c[k] = $urandom_range(1, 3);
        if (k != proc && pulse_c[k] > last_snoop) last_snoop = pulse_c[k];
      end
    end
    share_c = (last_snoop > 0) ? $urandom_range(1, last_snoop) : 0;
    dirty_c = (last_snoop > 0) ? $urandom_range(1, last_snoop) : 0;
    recv_start = (cmd == 2) ? 1 : last_snoop + 1;
    next_beat = recv_start;

    @(negedge clk);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", req_ready, 1'b1);
    req_valid = 1'b1;
    req_cmd   = cmd[1:0];
    req_proc  = p;
    req_addr  = addr;
    @(negedge clk);

    // Keep a junk request asserted while busy; it must not be accepted.
    req_cmd  = 2'($urandom_range(0, 3));
    req_proc = 2'($urandom_range(0, 3));
    req_addr = $urandom;

    done = 0; ack_now = 0; mem_active = 0; stable_ok = 1; busy_ready = 0;
    hdr_c = 0; last_c = 0; beat_i = 0; delay = 0;
    op.we = 1'b0; op.addr = '0; op.data = '0;
    cur = op;
    for (int c = 1; c <= 200 && !done; c++) begin
      if (c > 1) @(negedge clk);
      if (req_ready) busy_ready = 1;
      if (rsp_valid) begin
        obs.push_back({3'b000, rsp_is_addr, rsp_last, rsp_shared, rsp_proc, rsp_data});
        if (rsp_is_addr && hdr_c == 0) hdr_c = c;
        if (rsp_last) begin
          last_c = c;
          done = 1;
        end
      end

      if (ack_now) begin
        mem_ack = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        ack_now = 0;
        chk("mem_req_drop", mem_req, 1'b0);
      end else if (mem_req) begin
        if (!mem_active) begin
          mem_active = 1;
          cur.we = mem_we;
          cur.addr = mem_addr;
          cur.data = mem_wdata;
          stable_ok = 1;
          delay = $urandom_range(0, 2);
          if (exp_mem.size() == 0) begin
            chk("mem_unexpected", 1'b1, 1'b0);
            op = cur;
          end else begin
            op = exp_mem.pop_front();
          end
          chk("mem_we_addr", {cur.we, cur.addr}, {op.we, op.addr});
          if (op.we) chk("mem_wdata", cur.data, op.data);
        end else if ({mem_we, mem_addr, mem_wdata} !== {cur.we, cur.addr, cur.data}) begin
          stable_ok = 0;
        end
        if (delay == 0) begin
          mem_ack = 1'b1;
          mem_rdata = op.data;
          ack_now = 1;
          mem_active = 0;
          chk("mem_stable", stable_ok, 1'b1);
        end else begin
          delay--;
        end
      end

      sd = '0;
      for (int k = 0; k < 4; k++) if (pulse_c[k] == c) sd[k] = 1'b1;
      snoop_done  = sd;
      snoop_share = (cmd != 2) && share && (c == share_c);
      snoop_dirty = (cmd != 2) && dirty && (c == dirty_c);

      if ((cmd == 2 || dirty_path) && beat_i < 4 && c >= recv_start) begin
        if (c == next_beat) begin
          bus_wvalid = 1'b1;
          bus_wdata  = wd[beat_i];
          beat_i++;
          next_beat = c + 1 + $urandom_range(0, 2);
        end else begin
          bus_wvalid = 1'b0;
          bus_wdata  = $urandom;
        end
      end else begin
        bus_wvalid = ($urandom_range(0, 3) == 0);
        bus_wdata  = $urandom;
      end

      if (done) begin
        req_valid   = 1'b0;
        snoop_done  = '0;
        snoop_share = 1'b0;
        snoop_dirty = 1'b0;
        bus_wvalid  = 1'b0;
      end
    end

    if (!done) begin
      chk("timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      mem_ack = 1'b0;
    end
    chk("busy_ready", busy_ready, 1'b0);
    chk("mem_ops_left", exp_mem.size(), 0);
    chk("nbeats", obs.size(), 1 + nwords);
    for (int i = 0; i < obs.size() && i <= nwords; i++) begin
      if (i == 0) eb = {3'b000, 1'b1, (nwords == 0), exp_sh, p, addr};
      else        eb = {3'b000, 1'b0, (i == nwords), exp_sh, p, exp_line[(i-1)*32 +: 32]};
      nm = $sformatf("beat%0d", i);
      chk(nm, obs[i], eb);
    end
    if (done) chk("back_to_back", last_c - hdr_c, nwords);
    if (mode == 1) chk("hdr_latency", hdr_c, 3);
    @(negedge clk);
    chk("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1;
    req_valid = 1'b0; req_cmd = '0; req_proc = '0; req_addr = '0;
    snoop_done = '0; snoop_share = 1'b0; snoop_dirty = 1'b0;
    bus_wvalid = 1'b0; bus_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 64; i++) begin
      l3_v[i] = 1'b0; l3_d[i] = 1'b0; l3_tag[i] = '0; l3_data[i] = '0;
    end

    repeat (2) @(negedge clk);
    chk("reset_ctl", {req_ready, rsp_valid, rsp_is_addr, rsp_shared, rsp_last, mem_req, mem_we}, 7'b0);
    chk("reset_data", {rsp_proc, rsp_data, mem_addr}, 66'b0);
    chk("reset_wdata", mem_wdata, 128'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_post_reset", req_ready, 1'b1);

    // 1: cold GETS miss, then a best-case hit
    run_txn(0, 1, 32'h0000_1040, 1'b0, 1'b0, 0);
    run_txn(0, 1, 32'h0000_1040, 1'b0, 1'b0, 1);
    // 2: shared GETS, then GETX with sharers
    run_txn(0, 0, 32'h0000_1040, 1'b1, 1'b0, 0);
    run_txn(1, 2, 32'h0000_1040, 1'b1, 1'b0, 0);
    // 3: GETX with dirty owner; a conflicting GETS must write that line back
    run_txn(1, 0, 32'h0000_2000, 1'b0, 1'b1, 0);
    run_txn(0, 3, 32'h0000_2400, 1'b0, 1'b0, 0);
    // 4: PUTX then conflicting GETS: write-back then fill
    run_txn(2, 3, 32'h0000_0040, 1'b0, 1'b0, 0);
    run_txn(0, 1, 32'h0000_4040, 1'b0, 1'b0, 0);
    // 5: INV with snoops spread over three cycles
    run_txn(3, 1, 32'h0000_3000, 1'b1, 1'b0, 2);

    // random traffic over a few conflicting sets
    for (int t = 0; t < 40; t++) begin
      int cmd, proc;
      logic [31:0] a;
      bit sh, dy;
      cmd  = $urandom_range(0, 3);
      proc = $urandom_range(0, 3);
      a    = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      sh   = ($urandom_range(0, 1) == 1);
      dy   = (cmd < 2) && ($urandom_range(0, 2) == 0);
      run_txn(cmd, proc, a, sh, dy, 0);
    end

    // 6: reset while a fill is outstanding
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'd0; req_proc = 2'd2; req_addr = 32'h0000_5080;
    @(negedge clk);
    req_valid = 1'b0;
    snoop_done = 4'b1011;
    @(negedge clk);
    snoop_done = 4'b0000;
    w = 0;
    while (!mem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t6_mem_req_seen", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_mem_req_drop", mem_req, 1'b0);
    chk("t6_outputs", {req_ready, rsp_valid, rsp_last, mem_we, mem_addr}, 36'b0);
    for (int i = 0; i < 64; i++) begin
      l3_v[i] = 1'b0;
      l3_d[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_ready", req_ready, 1'b1);
    run_txn(0, 1, 32'h0000_1040, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
